seq_subtractor_64: RTL and testbench

//  Multi-cycle borrow-ripple subtractor: computes diff = a - b - bin, SLICE_W bits per clock.
//  It is the inverse-direction companion to the team's ripple-carry adder chain.
//  It serves datapaths that trade latency for area and need the difference, the borrow-out
//  and the signed-overflow flag behind a start/done handshake.

---
 rtl/seq_subtractor_64.sv | 138 +++++++++++++
 tb/tb_seq_subtractor_64.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_subtractor_64.sv
// Multi-cycle borrow-ripple subtractor: diff = a - b - bin, one SLICE_W-bit slice per clock.
// Start/done handshake; diff/bout/ovf hold the last completed result.
module seq_subtractor_64 #(
    parameter int WIDTH   = 64,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One slice of a - b - borrow as a + ~b + ~borrow; top bit is the carry (not-borrow).
    function automatic logic [SLICE_W:0] slice_sub(
        input logic [SLICE_W-1:0] x,
        input logic [SLICE_W-1:0] y,
        input logic               brw
    );
        slice_sub = {1'b0, x} + {1'b0, ~y} + {{SLICE_W{1'b0}}, ~brw};
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SLICE_W:0]   slice_s;
    logic               accept_s;

    // Next-state, slice datapath and result capture.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        slice_s  = slice_sub(a_q[cnt_q*SLICE_W +: SLICE_W],
                             b_q[cnt_q*SLICE_W +: SLICE_W], borrow_q);
        accept_s = start && (state_q != S_RUN);

        case (state_q)
            S_RUN: begin
                work_d[cnt_q*SLICE_W +: SLICE_W] = slice_s[SLICE_W-1:0];
                borrow_d = ~slice_s[SLICE_W];
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = {CNT_W{1'b0}};
                    diff_d  = work_d;
                    bout_d  = ~slice_s[SLICE_W];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (slice_s[SLICE_W-1] != a_q[WIDTH-1]);
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    state_d  = S_RUN;
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = {CNT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            work_q   <= {WIDTH{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_subtractor_64.sv
// Self-checking bench for seq_subtractor_64: directed cases, handshake corners and
// randomized operations compared against a plain-arithmetic reference model.
module tb_seq_subtractor_64;

    localparam int W   = 64;
    localparam int LAT = 17;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          bin;
    logic          busy;
    logic          done;
    logic [W-1:0]  diff;
    logic          bout;
    logic          ovf;

    int n_checks;
    int n_pass;

    seq_subtractor_64 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Start an operation (called just after a clock edge) and check its result.
    // poke>0 raises start with junk operands at that RUN cycle; it must be ignored.
    task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                          input logic rbin, input int poke);
        logic [W:0]   ref_full;
        logic [W-1:0] ref_diff;
        logic         ref_bout;
        logic         ref_ovf;
        int           cycles;
        int           busy_cnt;
        ref_full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
        ref_diff = ref_full[W-1:0];
        ref_bout = ref_full[W];
        ref_ovf  = (ra[W-1] != rb[W-1]) && (ref_diff[W-1] != ra[W-1]);
        a = ra; b = rb; bin = rbin; start = 1'b1;
        @(posedge clk); #1;
        a = rand64(); b = rand64(); bin = $urandom_range(0, 1);
        cycles   = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && cycles < 60) begin
            start = (cycles == poke);
            if (start) begin a = rand64(); b = rand64(); end
            @(posedge clk); #1;
            cycles++;
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        check("latency",    W'(cycles),   W'(LAT));
        check("busy_count", W'(busy_cnt), W'(LAT - 1));
        check("busy_in_done", W'(busy),   W'(0));
        check("diff", diff, ref_diff);
        check("bout", W'(bout), W'(ref_bout));
        check("ovf",  W'(ovf),  W'(ref_ovf));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, W'(busy), W'(0));
        check({tag, "_done"}, W'(done), W'(0));
        check({tag, "_diff"}, diff,     {W{1'b0}});
        check({tag, "_bout"}, W'(bout), W'(0));
        check({tag, "_ovf"},  W'(ovf),  W'(0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #3;
        check_zero_outputs("reset_init");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic cases.
        run_op(64'd100, 64'd58, 1'b0, 0);
        check("diff_42", diff, 64'd42);
        @(posedge clk); #1;
        check("done_one_cycle", W'(done), W'(0));
        run_op(64'd0, 64'd1, 1'b0, 0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 0);
        run_op(64'h0000_0001_0000_0000, 64'd0, 1'b1, 0);
        check("diff_cross8", diff, 64'h0000_0000_FFFF_FFFF);

        // Start while busy is ignored; back-to-back start from the done cycle.
        run_op(64'd1000, 64'd1, 1'b0, 5);
        run_op(64'd5, 64'd9, 1'b1, 0);

        // Asynchronous reset mid-RUN (cycle 7) aborts the operation.
        a = 64'd77; b = 64'd11; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset_mid_run");
        repeat (3) begin
            @(posedge clk); #1;
            check("no_done_in_reset", W'(done), W'(0));
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            check("no_done_after_abort", W'(done), W'(0));
        end
        run_op(64'd7, 64'd3, 1'b0, 0);
        check("diff_after_abort", diff, 64'd4);

        // Randomized operations with assorted boundary-heavy operand patterns.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = rand64(); rb = rand64(); end
                1: begin ra = rand64(); rb = ra; end
                2: begin ra = W'($urandom_range(0, 3)); rb = W'($urandom_range(0, 3)); end
                default: begin
                    ra = {$urandom_range(0, 1) ? 1'b1 : 1'b0, {(W-1){1'b0}}} ^ W'($urandom_range(0, 1));
                    rb = {$urandom_range(0, 1) ? 1'b0 : 1'b1, {(W-1){1'b1}}};
                end
            endcase
            run_op(ra, rb, $urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                check("rand_done_drop", W'(done), W'(0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
